// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Package : axi_pkg
// Shared AXI write-path types, response codes and helpers.     Rev 1.0
// ============================================================================
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } wr_state_t;

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_RESP_DECERR = 2'b11;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : axi_sync_fifo
// Synchronous FIFO with pointer-plus-wrap-bit full/empty.      Rev 1.0
// ============================================================================
module axi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int c_PTR_W = $clog2(DEPTH);

  logic [c_PTR_W:0] r_wr_ptr;
  logic [c_PTR_W:0] r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[c_PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_wr_slave.sv
`default_nettype none
// ============================================================================
// Module : axi_wr_slave
// AXI3 write slave: queued AW, one burst at a time, one B per burst. Rev 1.0
// ============================================================================
module axi_wr_slave
  import axi_pkg::*;
#(
  parameter int                ID_W        = 4,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                LEN_W       = 4,
  parameter int                AW_DEPTH    = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                REGION_LOG2 = 12
) (
  input  logic                a_clk,
  input  logic                a_reset,
  input  logic [ID_W-1:0]     aw_id,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [LEN_W-1:0]    aw_len,
  input  logic [2:0]          aw_size,
  input  logic [1:0]          aw_burst,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [ID_W-1:0]     w_id,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic                w_last,
  input  logic                w_valid,
  output logic                w_ready,
  output logic [ID_W-1:0]     b_id,
  output logic [1:0]          b_resp,
  output logic                b_valid,
  input  logic                b_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                w_id_err
);
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    burst_t            burst;
  } aw_req_t;

  localparam int         c_REQ_W    = $bits(aw_req_t);
  localparam logic [2:0] c_MAX_SIZE = 3'($clog2(DATA_W/8));

  wr_state_t           r_state, w_state_nx;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [2:0]          r_size;
  burst_t              r_burst;
  logic [LEN_W-1:0]    r_cnt;
  logic [1:0]          r_pop_resp;
  logic                r_wl_err;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W/8-1:0] r_mem_wstrb;
  logic                r_w_id_err;

  aw_req_t             w_push_req;
  aw_req_t             w_head;
  logic [c_REQ_W-1:0]  w_head_bits;
  logic                w_full, w_empty, w_pop;
  logic [1:0]          w_head_resp;
  logic [ADDR_W-1:0]   w_head_mask;
  logic                w_wrdy, w_bvld, w_hs, w_match;
  logic [ADDR_W-1:0]   w_bytes, w_wrap_bytes, w_next_addr;

  assign w_push_req = '{id: aw_id, addr: aw_addr, len: aw_len, size: aw_size,
                        burst: burst_t'(aw_burst)};
  assign w_head     = aw_req_t'(w_head_bits);
  assign aw_ready   = !w_full && !a_reset;

  axi_sync_fifo #(
    .WIDTH (c_REQ_W),
    .DEPTH (AW_DEPTH)
  ) u_aw_fifo (
    .clk     (a_clk),
    .rst     (a_reset),
    .i_push  (aw_valid && aw_ready),
    .i_data  (w_push_req),
    .i_pop   (w_pop),
    .o_data  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Burst legality is judged once, on the request as it leaves the FIFO
  assign w_head_mask = (ADDR_W'(1) << w_head.size) - ADDR_W'(1);
  always_comb begin
    w_head_resp = c_RESP_OKAY;
    if ((w_head.addr >> REGION_LOG2) != (BASE_ADDR >> REGION_LOG2)) begin
      w_head_resp = c_RESP_DECERR;
    end else if ((w_head.size > c_MAX_SIZE) || (w_head.burst == BURST_RSVD) ||
                 ((w_head.burst == BURST_WRAP) &&
                  (!wrap_len_ok(8'(w_head.len)) || ((w_head.addr & w_head_mask) != '0)))) begin
      w_head_resp = c_RESP_SLVERR;
    end
  end

  always_ff @(posedge a_clk) begin
    if (a_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nx;
  end

  assign w_hs    = w_valid && w_wrdy;
  assign w_match = w_hs && (w_id == r_id);

  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_wrdy     = 1'b0;
    w_bvld     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        w_wrdy = 1'b1;
        if (w_valid && (w_id == r_id) && (r_cnt == r_len)) w_state_nx = ST_RESP;
      end
      ST_RESP: begin
        w_bvld = 1'b1;
        if (b_ready) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign w_bytes      = ADDR_W'(1) << r_size;
  assign w_wrap_bytes = (ADDR_W'(r_len) + ADDR_W'(1)) << r_size;
  always_comb begin
    w_next_addr = r_addr;
    case (r_burst)
      BURST_INCR: w_next_addr = (r_addr & ~(w_bytes - ADDR_W'(1))) + w_bytes;
      BURST_WRAP: w_next_addr = (r_addr & ~(w_wrap_bytes - ADDR_W'(1))) |
                                ((r_addr + w_bytes) & (w_wrap_bytes - ADDR_W'(1)));
      default:    w_next_addr = r_addr;
    endcase
  end

  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= BURST_FIXED;
      r_cnt       <= '0;
      r_pop_resp  <= c_RESP_OKAY;
      r_wl_err    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_w_id_err  <= 1'b0;
    end else begin
      r_mem_we   <= 1'b0;
      r_w_id_err <= 1'b0;
      if (w_pop) begin
        r_id       <= w_head.id;
        r_addr     <= w_head.addr;
        r_len      <= w_head.len;
        r_size     <= w_head.size;
        r_burst    <= w_head.burst;
        r_cnt      <= '0;
        r_pop_resp <= w_head_resp;
        r_wl_err   <= 1'b0;
      end
      if (w_hs && !w_match) begin
        r_w_id_err <= 1'b1;
      end
      if (w_match) begin
        r_cnt  <= r_cnt + LEN_W'(1);
        r_addr <= w_next_addr;
        if (w_last != (r_cnt == r_len)) r_wl_err <= 1'b1;
        if (r_pop_resp == c_RESP_OKAY) begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_addr;
          r_mem_wdata <= w_data;
          r_mem_wstrb <= w_strb;
        end
      end
    end
  end

  assign w_ready   = w_wrdy;
  assign b_valid   = w_bvld;
  assign b_id      = r_id;
  // A decode or request error outranks a WLAST protocol error
  assign b_resp    = (r_pop_resp != c_RESP_OKAY) ? r_pop_resp :
                     (r_wl_err ? c_RESP_SLVERR : c_RESP_OKAY);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign w_id_err  = r_w_id_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_slave.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_wr_slave
// Directed self-checking bench for axi_wr_slave.               Rev 1.0
// ============================================================================
module tb_axi_wr_slave;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, LEN_W = 4;

  logic              a_clk = 1'b0;
  logic              a_reset = 1'b1;
  logic [ID_W-1:0]   aw_id = '0;
  logic [ADDR_W-1:0] aw_addr = '0;
  logic [LEN_W-1:0]  aw_len = '0;
  logic [2:0]        aw_size = '0;
  logic [1:0]        aw_burst = '0;
  logic              aw_valid = 1'b0;
  logic              aw_ready;
  logic [ID_W-1:0]   w_id = '0;
  logic [DATA_W-1:0] w_data = '0;
  logic [3:0]        w_strb = '0;
  logic              w_last = 1'b0;
  logic              w_valid = 1'b0;
  logic              w_ready;
  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;
  logic              b_valid;
  logic              b_ready = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              w_id_err;

  int n_vec = 0;
  int n_err = 0;

  axi_wr_slave #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .AW_DEPTH(4), .BASE_ADDR(32'h0), .REGION_LOG2(12)
  ) dut (
    .a_clk(a_clk), .a_reset(a_reset),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_id(w_id), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .w_id_err(w_id_err)
  );

  always #5 a_clk = ~a_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time %0t reached, required finish before 400000", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge a_clk);
    #1;
  endtask

  task automatic set_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
    aw_valid = 1'b1;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    set_aw(id, addr, len, size, burst);
    while (!aw_ready && n < 50) begin tick(); n++; end
    check("aw_accept", aw_ready, 1'b1);
    tick();
    aw_valid = 1'b0;
  endtask

  task automatic do_w(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                      input logic last);
    int n = 0;
    w_id = id; w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
    while (!w_ready && n < 50) begin tick(); n++; end
    check("w_accept", w_ready, 1'b1);
    tick();
    w_valid = 1'b0;
  endtask

  task automatic wait_b(input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    b_ready = 1'b1;
    while (!b_valid && n < 50) begin tick(); n++; end
    check("b_valid", b_valid, 1'b1);
    check("b_id", b_id, id);
    check("b_resp", b_resp, resp);
    tick();
    b_ready = 1'b0;
  endtask

  logic [31:0] exp_addr [4];
  logic [31:0] err_addr [4];
  logic [2:0]  err_size [4];
  logic [1:0]  err_burst [4];
  logic [1:0]  err_resp [4];

  initial begin
    // Reset state
    tick(); tick();
    check("rst_aw_ready", aw_ready, 1'b0);
    check("rst_w_ready", w_ready, 1'b0);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_b_id", b_id, 4'h0);
    check("rst_b_resp", b_resp, 2'b00);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", mem_wstrb, 4'h0);
    check("rst_w_id_err", w_id_err, 1'b0);
    a_reset = 1'b0;
    tick();
    check("post_rst_aw_ready", aw_ready, 1'b1);

    // Single beat with AW-to-W-ready latency
    do_aw(4'd0, 32'h0, 4'd0, 3'b010, 2'b01);
    check("lat_w_ready_pop", w_ready, 1'b0);
    tick();
    check("lat_w_ready", w_ready, 1'b1);
    do_w(4'd0, 32'hA5A5A5A5, 4'hF, 1'b1);
    check("single_we", mem_we, 1'b1);
    check("single_addr", mem_addr, 32'h0);
    check("single_data", mem_wdata, 32'hA5A5A5A5);
    check("single_strb", mem_wstrb, 4'hF);
    check("single_bvalid_rise", b_valid, 1'b1);
    tick();
    check("single_we_1cyc", mem_we, 1'b0);
    wait_b(4'd0, 2'b00);

    // INCR then WRAP, four beats each
    exp_addr = '{32'h10, 32'h14, 32'h18, 32'h1C};
    do_aw(4'd2, 32'h10, 4'd3, 3'b010, 2'b01);
    for (int j = 0; j < 4; j++) begin
      do_w(4'd2, 32'h1000_0000 + j, 4'h3, j == 3);
      check("incr_we", mem_we, 1'b1);
      check("incr_addr", mem_addr, exp_addr[j]);
      check("incr_strb", mem_wstrb, 4'h3);
    end
    wait_b(4'd2, 2'b00);

    exp_addr = '{32'h18, 32'h1C, 32'h10, 32'h14};
    do_aw(4'd3, 32'h18, 4'd3, 3'b010, 2'b10);
    for (int j = 0; j < 4; j++) begin
      do_w(4'd3, 32'h2000_0000 + j, 4'hF, j == 3);
      check("wrap_we", mem_we, 1'b1);
      check("wrap_addr", mem_addr, exp_addr[j]);
    end
    wait_b(4'd3, 2'b00);

    // Error bursts drain three beats without writing
    err_addr  = '{32'h1000, 32'h0, 32'h0, 32'h0};
    err_size  = '{3'b010, 3'b110, 3'b010, 3'b010};
    err_burst = '{2'b01, 2'b01, 2'b11, 2'b10};
    err_resp  = '{2'b11, 2'b10, 2'b10, 2'b10};
    for (int i = 0; i < 4; i++) begin
      do_aw(4'(i + 8), err_addr[i], 4'd2, err_size[i], err_burst[i]);
      for (int j = 0; j < 3; j++) begin
        do_w(4'(i + 8), 32'hDEAD_0000 + j, 4'hF, j == 2);
        check("err_no_write", mem_we, 1'b0);
      end
      wait_b(4'(i + 8), err_resp[i]);
    end

    // WLAST early on a two-beat burst: data still written, SLVERR reported
    do_aw(4'd4, 32'h20, 4'd1, 3'b010, 2'b01);
    do_w(4'd4, 32'h4444_0000, 4'hF, 1'b1);
    check("wlast_we0", mem_we, 1'b1);
    check("wlast_addr0", mem_addr, 32'h20);
    do_w(4'd4, 32'h4444_0001, 4'hF, 1'b1);
    check("wlast_addr1", mem_addr, 32'h24);
    wait_b(4'd4, 2'b10);

    // Stray W id
    do_aw(4'd1, 32'h40, 4'd0, 3'b010, 2'b01);
    do_w(4'd5, 32'hBAD0BAD0, 4'hF, 1'b1);
    check("stray_id_err", w_id_err, 1'b1);
    check("stray_no_write", mem_we, 1'b0);
    check("stray_w_ready", w_ready, 1'b1);
    do_w(4'd1, 32'h0101_0101, 4'hF, 1'b1);
    check("stray_id_err_drop", w_id_err, 1'b0);
    check("stray_good_we", mem_we, 1'b1);
    check("stray_good_addr", mem_addr, 32'h40);
    check("stray_good_data", mem_wdata, 32'h0101_0101);
    wait_b(4'd1, 2'b00);

    // FIFO fill while a burst occupies the FSM
    do_aw(4'd6, 32'h80, 4'd0, 3'b010, 2'b01);
    tick();
    for (int i = 0; i < 4; i++) do_aw(4'(i + 7), 32'h100 + 32'(i * 4), 4'd0, 3'b010, 2'b01);
    set_aw(4'd11, 32'h110, 4'd0, 3'b010, 2'b01);
    for (int k = 0; k < 3; k++) begin
      check("full_aw_ready", aw_ready, 1'b0);
      tick();
    end
    do_w(4'd6, 32'h6666_6666, 4'hF, 1'b1);
    check("full_aw_ready_resp", aw_ready, 1'b0);
    wait_b(4'd6, 2'b00);
    check("full_aw_ready_popcyc", aw_ready, 1'b0);
    tick();
    check("full_aw_ready_after_pop", aw_ready, 1'b1);
    tick();
    aw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_w(4'(i + 7), 32'h7000_0000 + i, 4'hF, 1'b1);
      check("q_we", mem_we, 1'b1);
      check("q_addr", mem_addr, 32'h100 + 32'(i * 4));
      if (i == 0) begin
        for (int k = 0; k < 10; k++) begin
          check("hold_b_valid", b_valid, 1'b1);
          check("hold_b_id", b_id, 4'd7);
          check("hold_b_resp", b_resp, 2'b00);
          check("hold_w_ready", w_ready, 1'b0);
          tick();
        end
      end
      wait_b(4'(i + 7), 2'b00);
    end

    // Reset mid-burst with a second request queued
    do_aw(4'd12, 32'h200, 4'd3, 3'b010, 2'b01);
    do_w(4'd12, 32'hC0C0_C0C0, 4'h5, 1'b0);
    check("mid_addr", mem_addr, 32'h200);
    do_aw(4'd13, 32'h300, 4'd0, 3'b010, 2'b01);
    a_reset = 1'b1;
    b_ready = 1'b1;
    tick();
    check("mrst_aw_ready", aw_ready, 1'b0);
    check("mrst_w_ready", w_ready, 1'b0);
    check("mrst_b_valid", b_valid, 1'b0);
    check("mrst_b_id", b_id, 4'h0);
    check("mrst_b_resp", b_resp, 2'b00);
    check("mrst_mem_we", mem_we, 1'b0);
    check("mrst_mem_addr", mem_addr, 32'h0);
    check("mrst_mem_wdata", mem_wdata, 32'h0);
    check("mrst_mem_wstrb", mem_wstrb, 4'h0);
    check("mrst_w_id_err", w_id_err, 1'b0);
    a_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mrst_idle_w_ready", w_ready, 1'b0);
      check("mrst_idle_b_valid", b_valid, 1'b0);
    end
    b_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
